line_unit: RTL and testbench



---
 rtl/line_unit.sv | 174 +++++++++++++++++
 tb/tb_line_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/line_unit.sv
// line_unit -- box-drawing execution unit of the graphic generator.
//
// Renders one scanline of a rectangular box, either outlined or filled, into
// the line buffer. It emits one palette-index pixel per clock at x offsets
// relative to the box. The caller adds the box origin and resolves the index
// through its palette. Each start pulse draws exactly one scanline, and the
// caller waits for done before issuing the next start.
//
// Parameters
//   LINE_W     border thickness in pixels, 1..15
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous reset, ACTIVE-HIGH despite its name
//   start      one-cycle pulse; accepted only while idle
//   dy         row being drawn, relative to the box top
//   width      box width in pixels
//   height     box height in pixels
//   fill       1 = interior pixels use fg_color
//   fg_color   border palette index
//   bg_color   interior palette index when fill = 0
//   dx         x offset of the current pixel (registered)
//   pixel_sel  palette index of the current pixel (registered)
//   pixel_wr   pixel write strobe (registered)
//   done       one-cycle pulse, coincident with the last pixel (registered)
//
// Build option
//   LINE_UNIT_TRANSPARENT_EN  when defined, interior pixels with fill = 0 and
//                             bg_color == 0 are not written. dx still advances,
//                             so timing is unchanged.

module line_unit #(
  parameter int LINE_W = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] dy,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic        fill,
  input  logic [3:0]  fg_color,
  input  logic [3:0]  bg_color,
  output logic [11:0] dx,
  output logic [3:0]  pixel_sel,
  output logic        pixel_wr,
  output logic        done
);

  localparam logic [11:0] LW = 12'(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_EMPTY = 2'd2
  } state_t;

  // r_state and r_cnt describe what the outputs are showing in the current
  // cycle. The output registers are therefore loaded from the next-state
  // values. This lets pixel 0 appear in the cycle right after start, even
  // though every output is registered.
  state_t      r_state, w_state_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;

  logic [11:0] r_dy, r_width, r_height;
  logic        r_fill;
  logic [3:0]  r_fg, r_bg;

  logic        w_take;
  logic [11:0] w_dy, w_width, w_height;
  logic        w_fill;
  logic [3:0]  w_fg, w_bg;

  logic        w_border;
  logic        w_skip;
  logic [3:0]  w_sel_nxt;
  logic        w_wr_nxt;
  logic        w_done_nxt;

  // Subtract LINE_W, clamping at zero. A box no thicker than two borders
  // then classifies every pixel as border without needing a special case.
  function automatic logic [11:0] sat_sub(input logic [11:0] a);
    return (a > LW) ? (a - LW) : 12'd0;
  endfunction

  function automatic logic is_border(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] w, input logic [11:0] h);
    return (x < LW) || (x >= sat_sub(w)) || (y < LW) || (y >= sat_sub(h));
  endfunction

  // The parameters are taken directly from the inputs in the start cycle,
  // so the first pixel can be classified before the latches have loaded.
  always_comb begin
    w_take   = (r_state == S_IDLE) && start;
    w_dy     = w_take ? dy       : r_dy;
    w_width  = w_take ? width    : r_width;
    w_height = w_take ? height   : r_height;
    w_fill   = w_take ? fill     : r_fill;
    w_fg     = w_take ? fg_color : r_fg;
    w_bg     = w_take ? bg_color : r_bg;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nxt   = 12'd0;
          w_state_nxt = ((width == 12'd0) || (dy >= height)) ? S_EMPTY : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == r_width - 12'd1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_EMPTY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_border = is_border(w_cnt_nxt, w_dy, w_width, w_height);
`ifdef LINE_UNIT_TRANSPARENT_EN
    w_skip = !w_border && !w_fill && (w_bg == 4'h0);
`else
    w_skip = 1'b0;
`endif
    w_sel_nxt  = 4'h0;
    w_wr_nxt   = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == S_RUN) begin
      w_sel_nxt  = (w_border || w_fill) ? w_fg : w_bg;
      w_wr_nxt   = !w_skip;
      w_done_nxt = (w_cnt_nxt == w_width - 12'd1);
    end else if (w_state_nxt == S_EMPTY) begin
      w_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 12'd0;
      dx        <= 12'd0;
      pixel_sel <= 4'h0;
      pixel_wr  <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      dx        <= w_cnt_nxt;
      pixel_sel <= w_sel_nxt;
      pixel_wr  <= w_wr_nxt;
      done      <= w_done_nxt;
    end
  end

  // The scanline parameters are only read while the state is RUN or EMPTY.
  // Those states are entered through a start, which loads these registers,
  // so they do not need a reset.
  always_ff @(posedge clk) begin
    r_dy     <= w_dy;
    r_width  <= w_width;
    r_height <= w_height;
    r_fill   <= w_fill;
    r_fg     <= w_fg;
    r_bg     <= w_bg;
  end

endmodule

// File: tb/tb_line_unit.sv
module tb_line_unit;

  localparam int LW = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] dy = '0, width = '0, height = '0;
  logic        fill = 1'b0;
  logic [3:0]  fg_color = '0, bg_color = '0;
  logic [11:0] dx;
  logic [3:0]  pixel_sel;
  logic        pixel_wr;
  logic        done;

  line_unit #(.LINE_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dy(dy), .width(width),
    .height(height), .fill(fill), .fg_color(fg_color), .bg_color(bg_color),
    .dx(dx), .pixel_sel(pixel_sel), .pixel_wr(pixel_wr), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dy; int w; int h; bit fill; int fg; int bg;
  } vec_t;

  typedef struct {
    logic [11:0] dx; logic [3:0] sel;
  } pix_t;

  pix_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic bit m_border(vec_t v, int x);
    return (x < LW) || (x >= v.w - LW) || (v.dy < LW) || (v.dy >= v.h - LW);
  endfunction

  function automatic bit m_write(vec_t v, int x);
`ifdef LINE_UNIT_TRANSPARENT_EN
    return m_border(v, x) || v.fill || (v.bg != 0);
`else
    return 1'b1;
`endif
  endfunction

  // Drives one scanline and checks every pixel against the scoreboard.
  // Sampling covers the cycles up to the one after done, so consecutive
  // calls issue start in the cycle right after done.
  task automatic run_line(input vec_t v, input int busy_cyc);
    int exp_done, done_cyc, nwr, exp_wr;
    bit empty;
    pix_t p;
    empty = (v.w == 0) || (v.dy >= v.h);
    exp_done = empty ? 1 : v.w;
    exp_wr = 0;
    dy = 12'(v.dy); width = 12'(v.w); height = 12'(v.h);
    fill = v.fill; fg_color = 4'(v.fg); bg_color = 4'(v.bg);
    start = 1'b1;
    if (!empty) begin
      for (int x = 0; x < v.w; x++) begin
        if (m_write(v, x)) begin
          p.dx = 12'(x);
          p.sel = (m_border(v, x) || v.fill) ? 4'(v.fg) : 4'(v.bg);
          sb.push_back(p);
          exp_wr++;
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    // Change the inputs after start; the DUT must keep its latched values.
    dy = 12'h003; width = 12'h002; height = 12'hFFF; fill = ~v.fill;
    fg_color = 4'hE; bg_color = 4'hD;
    done_cyc = 0; nwr = 0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (pixel_wr) begin
        nwr++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(dx), 32'hFFFF);
        end else begin
          p = sb.pop_front();
          chk("pix_dx", 32'(dx), 32'(p.dx));
          chk("pix_sel", 32'(pixel_sel), 32'(p.sel));
        end
      end
      if (done) begin
        if (done_cyc != 0) chk("double_done", 32'(c), 32'(done_cyc));
        else done_cyc = c;
        if (!empty) chk("done_dx", 32'(dx), 32'(v.w - 1));
      end
      start = (c == busy_cyc);
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("write_count", 32'(nwr), 32'(exp_wr));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{dy:0,  w:5,  h:4,  fill:0, fg:3, bg:7};   // top border row
    vecs[1] = '{dy:1,  w:5,  h:4,  fill:0, fg:3, bg:7};   // 3,7,7,7,3
    vecs[2] = '{dy:1,  w:5,  h:4,  fill:1, fg:3, bg:7};   // 3,3,3,3,3
    vecs[3] = '{dy:0,  w:0,  h:4,  fill:0, fg:3, bg:7};   // width 0
    vecs[4] = '{dy:4,  w:5,  h:4,  fill:0, fg:3, bg:7};   // dy == height
    vecs[5] = '{dy:1,  w:1,  h:4,  fill:0, fg:5, bg:6};   // single pixel
    vecs[6] = '{dy:1,  w:2,  h:5,  fill:0, fg:2, bg:9};   // too narrow: all border
    vecs[7] = '{dy:2,  w:6,  h:3,  fill:0, fg:4, bg:8};   // bottom row
    vecs[8] = '{dy:1,  w:5,  h:4,  fill:0, fg:3, bg:0};   // bg index 0
    vecs[9] = '{dy:5,  w:20, h:10, fill:0, fg:9, bg:12};  // wider box

    #2;
    chk("rst_dx", 32'(dx), 32'd0);
    chk("rst_sel", 32'(pixel_sel), 32'd0);
    chk("rst_wr", 32'(pixel_wr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);

    // Back-to-back through the table: each start follows the previous done.
    for (int i = 0; i < 10; i++) run_line(vecs[i], 0);

    // Start pulsed during RUN is ignored.
    run_line(vecs[1], 2);
    run_line(vecs[9], 7);

    // Abort with reset mid-scanline.
    @(negedge clk);
    dy = 12'd0; width = 12'd5; height = 12'd4; fill = 1'b0;
    fg_color = 4'd3; bg_color = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_dx", 32'(dx), 32'd2);
    chk("abort_pre_wr", 32'(pixel_wr), 32'd1);
    reset_n = 1'b1;
    #1;
    chk("abort_dx", 32'(dx), 32'd0);
    chk("abort_sel", 32'(pixel_sel), 32'd0);
    chk("abort_wr", 32'(pixel_wr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_wr", 32'(pixel_wr), 32'd0);
    end
    run_line(vecs[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
